// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit                                                 |
// | Purpose  : MEM-stage load/store engine with req/ack bus and fault reporting |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadEn,
  input  logic        MemWriteEn,
  input  logic [1:0]  MemType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        stall,
  output logic        exc_flag,
  output logic [1:0]  exc_cause
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_kill;
  logic [CW-1:0] r_tcnt;
  logic [1:0]    r_size;
  logic [1:0]    r_off;

  logic          w_access;
  logic          w_illegal;
  logic          w_misal;
  logic          w_tmo;
  logic          w_kill_now;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld_ext;

  assign w_access   = (MemReadEn | MemWriteEn) & ~flush;
  assign w_illegal  = (MemType == 2'd3) | (MemReadEn & MemWriteEn);
  assign w_misal    = ((MemType == 2'd1) & addr[0]) |
                      ((MemType == 2'd2) & (addr[1:0] != 2'b00));
  assign w_tmo      = (r_tcnt == CW'(TIMEOUT - 1));
  assign w_kill_now = r_kill | flush;

  assign stall = (r_state == S_BUSY) | ((r_state == S_IDLE) & w_access);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata;
    case (MemType)
      2'd0: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << addr[1:0];
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = wdata;
      end
    endcase
  end

  // Lane select uses the offset latched at request time, not the live addr.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'd0:    w_ld_ext = {{24{w_byte[7]}}, w_byte};
      2'd1:    w_ld_ext = {{16{w_half[15]}}, w_half};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_kill    <= 1'b0;
      r_tcnt    <= '0;
      r_size    <= 2'd0;
      r_off     <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      ld_data   <= 32'd0;
      ld_valid  <= 1'b0;
      exc_flag  <= 1'b0;
      exc_cause <= 2'd0;
    end else begin
      ld_valid <= 1'b0;
      exc_flag <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_illegal) begin
              exc_cause <= 2'b11;
              exc_flag  <= 1'b1;
              r_state   <= S_RESP;
            end else if (w_misal) begin
              exc_cause <= 2'b01;
              exc_flag  <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWriteEn;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= w_be;
              mem_wdata <= w_wdata;
              r_size    <= MemType;
              r_off     <= addr[1:0];
              r_tcnt    <= '0;
              r_kill    <= 1'b0;
              r_state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_kill  <= 1'b0;
            if (w_kill_now) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_RESP;
              if (!mem_we) begin
                ld_data  <= w_ld_ext;
                ld_valid <= 1'b1;
              end
            end
          end else if (w_tmo) begin
            mem_req <= 1'b0;
            r_kill  <= 1'b0;
            if (w_kill_now) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_RESP;
              exc_flag  <= 1'b1;
              exc_cause <= 2'b10;
              ld_data   <= 32'd0;
            end
          end else begin
            r_tcnt <= r_tcnt + CW'(1);
            if (flush) begin
              r_kill <= 1'b1;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store engine for the RISC-V pipeline. Consumes the decoded memory controls (MemReadEn, MemWriteEn, MemType) together with the ALU-computed address and store data. Runs a req/ack transaction on the data-memory bus, aligns and sign-extends load data, stalls the pipeline while busy, and reports access faults on an exception flag that feeds the decoder's exception input.

## Interface
- TIMEOUT, 16: max BUSY cycles waiting for mem_ack before a bus fault (≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- MemReadEn  in  1  load request from EX/MEM register.
- MemWriteEn  in  1  store request from EX/MEM register.
- MemType  in  2  access size: 0 byte, 1 halfword, 2 word, 3 reserved.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2), LSBs significant.
- flush  in  1  pipeline flush; discard current access result.
- mem_req  out  1  bus request, held until ack or timeout.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  bus read data, valid with mem_ack.
- mem_ack  in  1  bus completion, sampled only while mem_req=1.
- ld_data  out  32  extended load result.
- ld_valid  out  1  one-cycle pulse: ld_data valid.
- stall  out  1  hold IF..MEM stages.
- exc_flag  out  1  one-cycle fault pulse.
- exc_cause  out  2  01 misaligned, 10 bus timeout, 11 illegal access.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, access = MemReadEn|MemWriteEn, flush=0:
  - fault check, priority: illegal (MemType=3, or both enables set) > misaligned (half with addr[0]=1; word with addr[1:0]≠0).
  - On fault: go to RESP with exc_cause latched; no bus access.
  - Otherwise: latch mem_we, mem_addr, mem_be, mem_wdata, size, addr[1:0]; set mem_req; go to BUSY.
- IDLE with flush=1: access ignored; stay IDLE.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- BUSY:
  - mem_ack=1: drop mem_req; capture extracted load data; go to RESP.
  - No ack after TIMEOUT BUSY cycles: drop mem_req; cause 10; ld_data=0; go to RESP.
  - flush seen at any point in BUSY: sticky kill bit set. Bus completes normally, then the FSM returns to IDLE instead of RESP; no ld_valid, no exc_flag.
- Load extraction: byte lane addr[1:0], sign-extended; half lane addr[1], sign-extended; word unchanged.
- RESP:
  - ld_valid=1 for a successful load; exc_flag=1 on fault.
  - ld_data holds its value until the next RESP.
  - Always go to IDLE.
- Stores never pulse ld_valid.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, ld_data 0, ld_valid 0, exc_flag 0, exc_cause 0, timeout counter 0, kill 0.
- stall is combinational: 1 in IDLE with a non-flushed access present, and 1 throughout BUSY; 0 in RESP and in idle IDLE.
- mem_req rises the cycle after access presentation. Ack sampled at the edge; ack in first BUSY cycle gives RESP in cycle 2.
- Minimum access = 3 cycles (stall high in cycles 0–1). Each extra ack wait adds one cycle.
- Fault path: 2 cycles (stall in cycle 0, exc_flag in cycle 1).
- In RESP the EX/MEM register still holds the same instruction; IDLE ignores nothing, so the next instruction is evaluated the following cycle.
- rst mid-BUSY: mem_req 0 the next cycle; late acks are ignored; no ld_valid or exc_flag.
- mem_ack while mem_req=0 is ignored.

## Test plan
- LW addr 0x100, ack 2 cycles after req, mem_rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, stall high 3 cycles, ld_valid with ld_data 0xDEADBEEF.
- LB addr 0x203, mem_rdata 0x80112233 -> be 1000, ld_data 0xFFFFFF80. Same access with rdata 0x7F000000 -> 0x0000007F.
- SH addr 0x302, wdata 0x0000ABCD -> mem_we 1, be 1100, mem_wdata 0xABCDABCD, no ld_valid.
- LW addr 0x102 -> no mem_req; exc_flag=1 with cause 01 in cycle 1. MemType=3 -> cause 11.
- LW with ack never asserted, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles, exc_flag=1 with cause 10, ld_data 0.
- flush during BUSY, then ack -> no ld_valid or exc_flag, return to IDLE. rst during BUSY -> all outputs 0 the next cycle.
